// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bus of the SAR search controller: start request, comparator
// flags in, registered probe/result/status out.
interface sar_search_ctrl_if #(
    parameter int unsigned W = 4
);
    logic         start;
    logic         aeqb;
    logic         agtb;
    logic         altb;
    logic [W-1:0] probe;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         err;
    logic         hit;

    // Requester / comparator side
    modport master (
        output start, aeqb, agtb, altb,
        input  probe, result, busy, done, err, hit
    );

    // Search controller side
    modport slave (
        input  start, aeqb, agtb, altb,
        output probe, result, busy, done, err, hit
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving the b operand of a
// magnitude comparator and recovering the unknown a operand bit by bit.
// Optional feature: define SAR_EARLY_EXIT_EN to stop the search on an exact
// match (aeqb) and flag it on hit; otherwise hit is constant 0.
module sar_search_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic              clk,
    input  logic              rst,
    sar_search_ctrl_if.slave  bus
);
    localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t         state_q, state_n;
    logic [W-1:0]   probe_q, probe_n;
    logic [W-1:0]   result_q, result_n;
    logic [KW-1:0]  k_q, k_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic           err_q, err_n;
    logic           hit_q, hit_n;
    logic [2:0]     flags_c;
    logic           onehot_c;

    assign flags_c  = {bus.aeqb, bus.agtb, bus.altb};
    assign onehot_c = (flags_c == 3'b001) || (flags_c == 3'b010) || (flags_c == 3'b100);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            probe_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            probe_q  <= probe_n;
            result_q <= result_n;
            k_q      <= k_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            err_q    <= err_n;
            hit_q    <= hit_n;
        end
    end

    // Next-state and next-output logic; flags are judged against the current probe
    always_comb begin
        state_n  = state_q;
        probe_n  = probe_q;
        result_n = result_q;
        k_n      = k_q;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = err_q;
        hit_n    = hit_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts start exactly like IDLE for back-to-back searches
                if (bus.start) begin
                    state_n  = S_SEARCH;
                    result_n = '0;
                    k_n      = KW'(W - 1);
                    probe_n  = W'(1) << (W - 1);
                    err_n    = 1'b0;
                    hit_n    = 1'b0;
                    busy_n   = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SEARCH: begin
                busy_n = 1'b1;
                if (!onehot_c) begin
                    // Protocol violation: keep the partial result and stop
                    err_n   = 1'b1;
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    // Probe already holds result with bit k set, so a >= probe keeps it
                    if (bus.agtb || bus.aeqb) begin
                        result_n = probe_q;
                    end
`ifdef SAR_EARLY_EXIT_EN
                    if (bus.aeqb) begin
                        hit_n   = 1'b1;
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else
`endif
                    if (k_q == '0) begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        k_n     = k_q - KW'(1);
                        probe_n = result_n | (W'(1) << k_n);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.probe  = probe_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.hit    = hit_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: an ideal comparator is modelled on
// the bus, expected probes/results come from an interval-bisection model.
module tb_sar_search_ctrl;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_search_ctrl_if #(.W(W)) bus ();

    sar_search_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Ideal comparator on a_val, with an override to inject bad flag patterns
    logic [W-1:0] a_val;
    logic         force_en;
    logic [2:0]   force_flags;
    assign bus.aeqb = force_en ? force_flags[2] : (a_val == bus.probe);
    assign bus.agtb = force_en ? force_flags[1] : (a_val >  bus.probe);
    assign bus.altb = force_en ? force_flags[0] : (a_val <  bus.probe);

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_probe [W];
    int           exp_steps;
    logic [W-1:0] exp_result;
    logic         exp_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bisection over the interval [lo, hi): probe is the midpoint
    task automatic model(input logic [W-1:0] a);
        int lo;
        int hi;
        int mid;
        lo        = 0;
        hi        = 1 << W;
        exp_steps = 0;
        exp_hit   = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            mid          = (lo + hi) / 2;
            exp_probe[i] = W'(mid);
            exp_steps++;
`ifdef SAR_EARLY_EXIT_EN
            if (int'(a) == mid) begin
                lo      = mid;
                exp_hit = 1'b1;
                break;
            end
`endif
            if (int'(a) >= mid) lo = mid;
            else                hi = mid;
        end
        exp_result = W'(lo);
    endtask

    // Called at a negedge; leaves the bench at the negedge of the done cycle
    task automatic do_search(input logic [W-1:0] a, input bit hold, input bit mid_pulse);
        model(a);
        a_val     = a;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        check("err_clear_on_start", 32'(bus.err), 32'd0);
        for (int s = 0; s < exp_steps; s++) begin
            if (mid_pulse && s == 1) bus.start = 1'b1;
            if (mid_pulse && s == 2 && !hold) bus.start = 1'b0;
            check("busy", 32'(bus.busy), 32'd1);
            check("probe", 32'(bus.probe), 32'(exp_probe[s]));
            check("done_low", 32'(bus.done), 32'd0);
            @(negedge clk);
        end
        if (!hold) bus.start = 1'b0;
        check("done", 32'(bus.done), 32'd1);
        check("busy_end", 32'(bus.busy), 32'd0);
        check("result", 32'(bus.result), 32'(exp_result));
        check("err", 32'(bus.err), 32'd0);
        check("hit", 32'(bus.hit), 32'(exp_hit));
    endtask

    // One idle cycle after a done pulse: outputs held, pulse gone
    task automatic idle_check();
        @(negedge clk);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_result", 32'(bus.result), 32'(exp_result));
        check("idle_probe", 32'(bus.probe), 32'(exp_probe[exp_steps-1]));
    endtask

    // Inject a bad flag pattern at edge E(v+1); result keeps the top v bits of a
    task automatic violation(input logic [W-1:0] a, input int v_in, input logic [2:0] bad);
        int v;
        logic [W-1:0] part;
        model(a);
        v = (v_in >= exp_steps) ? exp_steps - 1 : v_in;
        part = (v == 0) ? '0 : W'((int'(a) >> (W - v)) << (W - v));
        a_val     = a;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < v; i++) begin
            check("viol_probe", 32'(bus.probe), 32'(exp_probe[i]));
            @(negedge clk);
        end
        force_en    = 1'b1;
        force_flags = bad;
        @(negedge clk);
        force_en = 1'b0;
        check("viol_done", 32'(bus.done), 32'd1);
        check("viol_err", 32'(bus.err), 32'd1);
        check("viol_busy", 32'(bus.busy), 32'd0);
        check("viol_result", 32'(bus.result), 32'(part));
        @(negedge clk);
        check("viol_err_sticky", 32'(bus.err), 32'd1);
        check("viol_done_once", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] bad_set [5];
        bit hold;
        bad_set[0] = 3'b000; bad_set[1] = 3'b011; bad_set[2] = 3'b101;
        bad_set[3] = 3'b110; bad_set[4] = 3'b111;

        rst         = 1'b1;
        bus.start   = 1'b0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        a_val       = '0;
        repeat (3) @(negedge clk);
        check("rst_probe", 32'(bus.probe), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_hit", 32'(bus.hit), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases and boundaries
        do_search(4'b1011, 1'b0, 1'b0); idle_check();
        do_search(4'b1000, 1'b0, 1'b0); idle_check();
        do_search(4'b0000, 1'b0, 1'b0); idle_check();
        do_search(4'b1111, 1'b0, 1'b0); idle_check();

        // Back-to-back with start held high, then a start pulse during SEARCH
        do_search(4'b0110, 1'b1, 1'b0);
        do_search(4'b1001, 1'b1, 1'b0);
        do_search(4'b0011, 1'b0, 1'b0); idle_check();
        do_search(4'b1011, 1'b0, 1'b1); idle_check();

        // Flag violation at E2 (all flags low), then err clears on next start
        violation(4'b1011, 1, 3'b000);
        do_search(4'b0101, 1'b0, 1'b0); idle_check();
        violation(4'b0100, 0, 3'b111);

        // Reset mid-search: asserted so that E2 samples it
        a_val     = 4'b1101;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_probe", 32'(bus.probe), 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        check("midrst_hit", 32'(bus.hit), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(bus.done), 32'd0);
        end

        // Randomized searches and violations
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                violation(W'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          bad_set[$urandom_range(0, 4)]);
            end else begin
                hold = 1'($urandom_range(0, 1));
                do_search(W'($urandom_range(0, 15)), hold, 1'($urandom_range(0, 1)));
                if (!hold && $urandom_range(0, 1) == 1) idle_check();
            end
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
